// File: rtl/dfd_clkgate_ctrl_pkg.sv
// Shared types and default parameters for the debug-fabric clock-gate controller.
package dfd_clkgate_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OFF   = 2'd2,
        ST_WAKE  = 2'd3
    } state_e;

    localparam int unsigned DEF_IDLE_CNT_W = 8;
    localparam int unsigned DEF_WAKE_DLY   = 2;
    localparam int unsigned DEF_EVT_CNT_W  = 16;

endpackage

// File: rtl/dfd_clkgate_ctrl_if.sv
// Control/status bundle between the gated-domain parent and the clock-gate controller.
interface dfd_clkgate_ctrl_if
    import dfd_clkgate_pkg::*;
#(
    parameter int unsigned IDLE_CNT_W = DEF_IDLE_CNT_W,
    parameter int unsigned EVT_CNT_W  = DEF_EVT_CNT_W
);

    logic                  busy;
    logic                  wake_req;
    logic                  force_on;
    logic [IDLE_CNT_W-1:0] idle_thresh;
    logic                  evt_clr;
    logic                  clk_en;
    logic                  wake_ack;
    logic                  gated;
    logic [EVT_CNT_W-1:0]  gate_evt_cnt;

    modport master (
        output busy,
        output wake_req,
        output force_on,
        output idle_thresh,
        output evt_clr,
        input  clk_en,
        input  wake_ack,
        input  gated,
        input  gate_evt_cnt
    );

    modport slave (
        input  busy,
        input  wake_req,
        input  force_on,
        input  idle_thresh,
        input  evt_clr,
        output clk_en,
        output wake_ack,
        output gated,
        output gate_evt_cnt
    );

endinterface

// File: rtl/dfd_clkgate_ctrl_sat_counter.sv
// Saturating up-counter with a clear that overrides increment.
module dfd_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/dfd_clkgate_ctrl.sv
// Idle-drain / wake FSM driving the enable of a gated debug-domain clock.
module dfd_clkgate_ctrl
    import dfd_clkgate_pkg::*;
#(
    parameter int unsigned IDLE_CNT_W = DEF_IDLE_CNT_W,
    parameter int unsigned WAKE_DLY   = DEF_WAKE_DLY,
    parameter int unsigned EVT_CNT_W  = DEF_EVT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    dfd_clkgate_ctrl_if.slave bus
);

    // WAKE_DLY must be at least 1 and WAKE_DLY-1 must fit in the drain counter.
    localparam logic [IDLE_CNT_W-1:0] WAKE_LOAD = IDLE_CNT_W'(WAKE_DLY - 1);

    state_e                r_state;
    logic [IDLE_CNT_W-1:0] r_cnt;
    logic                  r_clk_en;
    logic                  r_gated;
    logic                  r_wake_ack;

    state_e                w_next_state;
    logic [IDLE_CNT_W-1:0] w_next_cnt;
    logic                  w_act;
    logic                  w_gate_evt;
    logic [EVT_CNT_W-1:0]  w_evt_cnt;

    assign w_act = bus.busy | bus.wake_req | bus.force_on;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_gate_evt   = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (!w_act) begin
                    w_next_state = ST_DRAIN;
                    w_next_cnt   = bus.idle_thresh;
                end
            end
            ST_DRAIN: begin
                // Activity wins over an expiring drain; cnt is reloaded only on the next RUN exit.
                if (w_act) begin
                    w_next_state = ST_RUN;
                end else if (r_cnt == '0) begin
                    w_next_state = ST_OFF;
                    w_gate_evt   = 1'b1;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            ST_OFF: begin
                if (w_act) begin
                    w_next_state = ST_WAKE;
                    w_next_cnt   = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // Activity is ignored here: the clock must settle before gating is reconsidered.
                if (r_cnt == '0) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    // Outputs are registered from next_state so they move together with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_clk_en   <= 1'b1;
            r_gated    <= 1'b0;
            r_wake_ack <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_clk_en   <= (w_next_state != ST_OFF);
            r_gated    <= (w_next_state == ST_OFF);
            r_wake_ack <= bus.wake_req & (w_next_state == ST_RUN);
        end
    end

    dfd_sat_counter #(
        .WIDTH (EVT_CNT_W)
    ) u_evt_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_gate_evt),
        .i_clr (bus.evt_clr),
        .o_cnt (w_evt_cnt)
    );

    assign bus.clk_en       = r_clk_en;
    assign bus.gated        = r_gated;
    assign bus.wake_ack     = r_wake_ack;
    assign bus.gate_evt_cnt = w_evt_cnt;

endmodule

// File: tb/tb_dfd_clkgate_ctrl.sv
// Directed bench for dfd_clkgate_ctrl: drain/gate timing, wake handshake, overrides, counter.
module tb_dfd_clkgate_ctrl;

    logic clk;
    logic reset;
    logic reset2;

    int n_cmp = 0;
    int n_err = 0;

    dfd_clkgate_ctrl_if #(.IDLE_CNT_W(8), .EVT_CNT_W(16)) bus ();
    dfd_clkgate_ctrl_if #(.IDLE_CNT_W(8), .EVT_CNT_W(3))  bus2 ();

    dfd_clkgate_ctrl #(.IDLE_CNT_W(8), .WAKE_DLY(2), .EVT_CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Narrow event counter instance so saturation is reachable in a short run.
    dfd_clkgate_ctrl #(.IDLE_CNT_W(8), .WAKE_DLY(2), .EVT_CNT_W(3)) dut_sat (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.busy = 1'b0; bus.wake_req = 1'b0; bus.force_on = 1'b0;
        bus.evt_clr = 1'b0; bus.idle_thresh = 8'd3;
        tick(3);
        n_cmp++; if (bus.clk_en !== 1'b1) begin n_err++; $display("FAIL reset_clk_en: got %b want 1", bus.clk_en); end
        n_cmp++; if (bus.gated !== 1'b0) begin n_err++; $display("FAIL reset_gated: got %b want 0", bus.gated); end
        n_cmp++; if (bus.wake_ack !== 1'b0) begin n_err++; $display("FAIL reset_wake_ack: got %b want 0", bus.wake_ack); end
        n_cmp++; if (bus.gate_evt_cnt !== 16'd0) begin n_err++; $display("FAIL reset_evt_cnt: got %0d want 0", bus.gate_evt_cnt); end
        reset = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            n_cmp++;
            if (bus.clk_en !== (e <= 4)) begin
                n_err++; $display("FAIL idle_clk_en edge %0d: got %b want %b", e, bus.clk_en, (e <= 4));
            end
            n_cmp++;
            if (bus.gated !== (e == 5)) begin
                n_err++; $display("FAIL idle_gated edge %0d: got %b want %b", e, bus.gated, (e == 5));
            end
        end
        n_cmp++; if (bus.gate_evt_cnt !== 16'd1) begin n_err++; $display("FAIL idle_evt_cnt: got %0d want 1", bus.gate_evt_cnt); end
    endtask

    task automatic test_wake();
        bus.wake_req = 1'b1;
        tick();
        n_cmp++; if (bus.clk_en !== 1'b1 || bus.gated !== 1'b0) begin n_err++; $display("FAIL wake_clk_en_j1: got en=%b gated=%b want en=1 gated=0", bus.clk_en, bus.gated); end
        n_cmp++; if (bus.wake_ack !== 1'b0) begin n_err++; $display("FAIL wake_ack_j1: got %b want 0", bus.wake_ack); end
        tick();
        n_cmp++; if (bus.wake_ack !== 1'b0) begin n_err++; $display("FAIL wake_ack_j2: got %b want 0", bus.wake_ack); end
        tick();
        n_cmp++; if (bus.wake_ack !== 1'b1) begin n_err++; $display("FAIL wake_ack_j3: got %b want 1", bus.wake_ack); end
        tick();
        n_cmp++; if (bus.wake_ack !== 1'b1) begin n_err++; $display("FAIL wake_ack_hold: got %b want 1", bus.wake_ack); end
        bus.wake_req = 1'b0;
        tick();
        n_cmp++; if (bus.wake_ack !== 1'b0 || bus.clk_en !== 1'b1) begin n_err++; $display("FAIL wake_release: got ack=%b en=%b want ack=0 en=1", bus.wake_ack, bus.clk_en); end
        tick(3);
        n_cmp++; if (bus.clk_en !== 1'b1) begin n_err++; $display("FAIL wake_drain_en: got %b want 1", bus.clk_en); end
        tick();
        n_cmp++; if (bus.gated !== 1'b1 || bus.clk_en !== 1'b0) begin n_err++; $display("FAIL wake_regate: got gated=%b en=%b want gated=1 en=0", bus.gated, bus.clk_en); end
        n_cmp++; if (bus.gate_evt_cnt !== 16'd2) begin n_err++; $display("FAIL wake_evt_cnt: got %0d want 2", bus.gate_evt_cnt); end
    endtask

    task automatic test_drain_abort();
        int drops = 0;
        bus.wake_req = 1'b1;
        tick(3);
        bus.busy = 1'b1; bus.wake_req = 1'b0;
        tick();
        bus.busy = 1'b0;
        tick(3);
        bus.busy = 1'b1;
        tick();
        if (bus.clk_en !== 1'b1) drops++;
        bus.busy = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (bus.clk_en !== 1'b1) drops++;
        end
        n_cmp++; if (drops != 0) begin n_err++; $display("FAIL abort_no_drop: got %0d drops want 0", drops); end
        tick();
        n_cmp++; if (bus.gated !== 1'b1) begin n_err++; $display("FAIL abort_full_drain: got gated=%b want 1", bus.gated); end
        n_cmp++; if (bus.gate_evt_cnt !== 16'd3) begin n_err++; $display("FAIL abort_evt_cnt: got %0d want 3", bus.gate_evt_cnt); end
    endtask

    task automatic test_thresh0();
        bus.wake_req = 1'b1;
        tick(3);
        bus.busy = 1'b1; bus.wake_req = 1'b0; bus.idle_thresh = 8'd0;
        tick();
        bus.busy = 1'b0;
        tick();
        n_cmp++; if (bus.clk_en !== 1'b1) begin n_err++; $display("FAIL t0_drain_en: got %b want 1", bus.clk_en); end
        tick();
        n_cmp++; if (bus.gated !== 1'b1 || bus.clk_en !== 1'b0) begin n_err++; $display("FAIL t0_off: got gated=%b en=%b want gated=1 en=0", bus.gated, bus.clk_en); end
        n_cmp++; if (bus.gate_evt_cnt !== 16'd4) begin n_err++; $display("FAIL t0_evt_cnt: got %0d want 4", bus.gate_evt_cnt); end
    endtask

    task automatic test_force_on();
        int drops = 0;
        bus.force_on = 1'b1;
        tick();
        n_cmp++; if (bus.clk_en !== 1'b1) begin n_err++; $display("FAIL force_wake_en: got %b want 1", bus.clk_en); end
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bus.clk_en !== 1'b1 || bus.gated !== 1'b0) drops++;
        end
        n_cmp++; if (drops != 0) begin n_err++; $display("FAIL force_hold: got %0d drops want 0", drops); end
        n_cmp++; if (bus.gate_evt_cnt !== 16'd4) begin n_err++; $display("FAIL force_evt_cnt: got %0d want 4", bus.gate_evt_cnt); end
        bus.force_on = 1'b0;
        tick(2);
        n_cmp++; if (bus.gated !== 1'b1 || bus.gate_evt_cnt !== 16'd5) begin n_err++; $display("FAIL force_release: got gated=%b cnt=%0d want gated=1 cnt=5", bus.gated, bus.gate_evt_cnt); end
    endtask

    task automatic test_simultaneous();
        bus.idle_thresh = 8'd2;
        bus.force_on = 1'b1;
        tick(2);
        bus.force_on = 1'b0;
        for (int e = 0; e <= 3; e++) begin
            tick();
            n_cmp++;
            if (bus.clk_en !== 1'b1) begin n_err++; $display("FAIL wake_cnt0_drop edge %0d: got en=%b want 1", e, bus.clk_en); end
        end
        tick();
        n_cmp++; if (bus.gated !== 1'b1) begin n_err++; $display("FAIL wake_cnt0_off: got %b want 1", bus.gated); end
        bus.force_on = 1'b1;
        tick(3);
        bus.force_on = 1'b0;
        tick(3);
        bus.busy = 1'b1;
        tick();
        n_cmp++; if (bus.clk_en !== 1'b1 || bus.gated !== 1'b0) begin n_err++; $display("FAIL drain_cnt0_act: got en=%b gated=%b want en=1 gated=0", bus.clk_en, bus.gated); end
        tick();
        bus.busy = 1'b0;
        tick(3);
        n_cmp++; if (bus.clk_en !== 1'b1) begin n_err++; $display("FAIL drain_reload: got %b want 1", bus.clk_en); end
        tick();
        n_cmp++; if (bus.gated !== 1'b1 || bus.gate_evt_cnt !== 16'd7) begin n_err++; $display("FAIL drain_reload_off: got gated=%b cnt=%0d want gated=1 cnt=7", bus.gated, bus.gate_evt_cnt); end
    endtask

    task automatic test_evt_clr();
        bus.evt_clr = 1'b1;
        tick();
        bus.evt_clr = 1'b0;
        n_cmp++; if (bus.gate_evt_cnt !== 16'd0) begin n_err++; $display("FAIL clr_plain: got %0d want 0", bus.gate_evt_cnt); end
        bus.force_on = 1'b1;
        tick(3);
        bus.force_on = 1'b0;
        tick(3);
        bus.evt_clr = 1'b1;
        tick();
        bus.evt_clr = 1'b0;
        n_cmp++; if (bus.gated !== 1'b1 || bus.gate_evt_cnt !== 16'd0) begin n_err++; $display("FAIL clr_vs_inc: got gated=%b cnt=%0d want gated=1 cnt=0", bus.gated, bus.gate_evt_cnt); end
        bus.force_on = 1'b1;
        tick(3);
        bus.force_on = 1'b0;
        tick(4);
        n_cmp++; if (bus.gate_evt_cnt !== 16'd1) begin n_err++; $display("FAIL clr_recount: got %0d want 1", bus.gate_evt_cnt); end
    endtask

    task automatic test_saturation();
        bus2.busy = 1'b0; bus2.wake_req = 1'b0; bus2.force_on = 1'b0;
        bus2.evt_clr = 1'b0; bus2.idle_thresh = 8'd0;
        reset2 = 1'b0;
        tick(2);
        n_cmp++; if (bus2.gate_evt_cnt !== 3'd1) begin n_err++; $display("FAIL sat_first: got %0d want 1", bus2.gate_evt_cnt); end
        for (int i = 2; i <= 9; i++) begin
            bus2.wake_req = 1'b1;
            tick(3);
            bus2.wake_req = 1'b0;
            tick(2);
            n_cmp++;
            if (bus2.gate_evt_cnt !== 3'((i > 7) ? 7 : i)) begin
                n_err++; $display("FAIL sat_event %0d: got %0d want %0d", i, bus2.gate_evt_cnt, (i > 7) ? 7 : i);
            end
        end
    endtask

    task automatic test_reset_mid_wake();
        bus.idle_thresh = 8'd3;
        bus.wake_req = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        n_cmp++; if (bus.clk_en !== 1'b1 || bus.gated !== 1'b0) begin n_err++; $display("FAIL rst_wake_en: got en=%b gated=%b want en=1 gated=0", bus.clk_en, bus.gated); end
        n_cmp++; if (bus.wake_ack !== 1'b0) begin n_err++; $display("FAIL rst_wake_ack: got %b want 0", bus.wake_ack); end
        n_cmp++; if (bus.gate_evt_cnt !== 16'd0) begin n_err++; $display("FAIL rst_wake_cnt: got %0d want 0", bus.gate_evt_cnt); end
        bus.wake_req = 1'b0;
        reset = 1'b0;
        tick(4);
        n_cmp++; if (bus.clk_en !== 1'b1) begin n_err++; $display("FAIL rst_run_drain: got %b want 1", bus.clk_en); end
        tick();
        n_cmp++; if (bus.gated !== 1'b1) begin n_err++; $display("FAIL rst_run_off: got %b want 1", bus.gated); end
    endtask

    initial begin
        reset2 = 1'b1;
        bus2.busy = 1'b0; bus2.wake_req = 1'b0; bus2.force_on = 1'b0;
        bus2.evt_clr = 1'b0; bus2.idle_thresh = 8'd0;
        test_reset();
        test_wake();
        test_drain_abort();
        test_thresh0();
        test_force_on();
        test_simultaneous();
        test_evt_clr();
        test_saturation();
        test_reset_mid_wake();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dfd_clkgate_ctrl.md
# dfd_clkgate_ctrl

Controller for a gated clock domain in the debug/trace fabric. It watches domain activity and external wake requests, then drives the enable of the domain's clock-gate cell. After a programmable idle interval it drops the enable; on a wake request it restores the enable and returns a level handshake once the clock is stable. Runs on the free-running clock that feeds the gate cell; the parent instantiates the gate cell and ties its test enable.

## Interface
- IDLE_CNT_W, 8: width of idle threshold and drain counter
- WAKE_DLY, 2: cycles clk_en is held high before the domain counts as running (must be ≥1)
- EVT_CNT_W, 16: width of the saturating gate-event counter

- clk  in  1  free-running (ungated) clock
- reset  in  1  synchronous, active-high reset
- busy  in  1  domain activity; high keeps the clock on
- wake_req  in  1  level wake request; held high until wake_ack
- force_on  in  1  CSR override; high disables gating
- idle_thresh  in  IDLE_CNT_W  drain length minus one, quasi-static
- evt_clr  in  1  clears gate_evt_cnt
- clk_en  out  1  to gate-cell en
- wake_ack  out  1  domain clock running and wake_req honoured
- gated  out  1  high while state is OFF
- gate_evt_cnt  out  EVT_CNT_W  number of RUN/DRAIN→OFF transitions, saturating

## Operation
- Activity term act = busy | wake_req | force_on.
- States: RUN, DRAIN, OFF, WAKE.
- RUN: clk_en=1. If !act → DRAIN, load cnt=idle_thresh.
- DRAIN: clk_en=1. If act → RUN (cnt not reloaded until next RUN exit). Else if cnt==0 → OFF. Else cnt--.
- OFF: clk_en=0, gated=1. If act → WAKE, load cnt=WAKE_DLY-1.
- WAKE: clk_en=1. act is ignored. If cnt==0 → RUN, else cnt--. Gating cannot be re-entered from WAKE.
- busy originates in the gated domain and is therefore low while OFF. Wake from OFF relies on wake_req or force_on.
- wake_ack: registered. Next value = wake_req & (next_state==RUN). It deasserts the cycle after wake_req drops. While wake_req is high, the FSM stays in RUN.
- gate_evt_cnt increments on each DRAIN→OFF transition and saturates at all-ones. evt_clr has priority over an increment in the same cycle.
- Reset values: state RUN, clk_en=1, wake_ack=0, gated=0, cnt=0, gate_evt_cnt=0. The clock runs out of reset.
- A reset asserted mid-DRAIN, mid-OFF or mid-WAKE returns the block to RUN with clk_en=1 on the following cycle.
- idle_thresh changes take effect at the next RUN→DRAIN load only.

## Timing
- All outputs are flops. clk_en and gated are registered from next_state, so they change in the same cycle the state register updates.
- Idle edge k (RUN, act low) → DRAIN cycles k+1..k+1+idle_thresh → OFF, clk_en=0, at k+2+idle_thresh.
- Wake edge j (OFF, act high) → clk_en=1 at j+1 → RUN at j+1+WAKE_DLY → wake_ack at j+1+WAKE_DLY if wake_req is still high.
- Simultaneous cases:
  - act rising in the same cycle that DRAIN has cnt==0 → RUN (activity wins).
  - act dropping in the same cycle that WAKE has cnt==0 → RUN, then DRAIN next cycle.

## Structure
- Shared package dfd_clkgate_pkg holds:
  - the state enum (RUN, DRAIN, OFF, WAKE, 2 bits)
  - the default parameter constants
- One sub-module, dfd_sat_counter (parameterised width, inc, clr, saturating), used for gate_evt_cnt.
- The FSM and the down-counter are inline in dfd_clkgate_ctrl.

## Test plan
- Reset release with busy=0, idle_thresh=3 → clk_en=1 through cycle 4 after release, clk_en=0 and gated=1 at cycle 5, gate_evt_cnt=1.
- In OFF, assert wake_req at edge j with WAKE_DLY=2 → clk_en=1 at j+1, wake_ack=1 at j+3; drop wake_req → wake_ack=0 next cycle, then DRAIN.
- In DRAIN with cnt=1, pulse busy for one cycle → return to RUN. A full idle_thresh+1 DRAIN restarts afterward, and clk_en never drops.
- idle_thresh=0 → exactly one DRAIN cycle, OFF two cycles after busy falls. force_on=1 held → clk_en stays 1 for 1000 cycles and gate_evt_cnt is unchanged.
- Preload gate_evt_cnt to 0xFFFF, gate once more → stays 0xFFFF. evt_clr coincident with a gate event → 0.
- Assert reset during WAKE (cnt=1) → next cycle state RUN, clk_en=1, wake_ack=0, gate_evt_cnt=0.
